// File: rtl/vga_tile_arbiter.sv
// Tile RAM arbiter for a 40x30 text-mode VGA display: fixed-time display prefetch
// slots always win the single RAM port, and CPU accesses fill the remaining cycles.
module vga_tile_arbiter #(
  parameter int COLS  = 40,
  parameter int ROWS  = 30,
  parameter int HLAST = 784,
  parameter int VLAST = 524
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [10:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic [10:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  tile_idx,
  output logic        tile_valid
);

  localparam logic [9:0]  H_ACTIVE_END = 10'(COLS * 16 - 1);
  localparam logic [9:0]  V_ACTIVE     = 10'(ROWS * 16);
  localparam logic [5:0]  LAST_PF_COL  = 6'(COLS - 2);
  localparam logic [9:0]  H_NEXT_LINE  = 10'(HLAST - 1);
  localparam logic [9:0]  V_LAST       = 10'(VLAST);
  localparam logic [10:0] ADDR_LIMIT   = 11'(COLS * ROWS);

  typedef enum logic [1:0] {IDLE, CPU_WAIT, CPU_ACK} arbState_t;

  arbState_t   state;
  logic [9:0]  nextLine;
  logic        slotMid;
  logic        slotEnd;
  logic        dispSlot;
  logic        rowOk;
  logic        dispFetch;
  logic [4:0]  dispRow;
  logic [5:0]  dispCol;
  logic [10:0] dispAddr;
  logic        cpuLegal;
  logic        cpuIssue;
  logic        cpuDrive;
  logic [10:0] memAddrQ;
  logic        dispPend;
  logic        dispMiss;
  logic        cpuReadQ;

  // Slot positions depend only on the beam; the row check only decides whether
  // the slot actually touches the RAM.
  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    nextLine = (vCount == V_LAST) ? 10'd0 : vCount + 10'd1;
    slotMid  = (hCount[3:0] == 4'd14) && (hCount[9:4] <= LAST_PF_COL);
    slotEnd  = (hCount == H_NEXT_LINE);
    dispSlot = slotMid || slotEnd;
    if (slotEnd) begin
      dispRow = nextLine[8:4];
      dispCol = 6'd0;
      rowOk   = (nextLine < V_ACTIVE);
    end else begin
      dispRow = vCount[8:4];
      dispCol = hCount[9:4] + 6'd1;
      rowOk   = (vCount < V_ACTIVE);
    end
    dispAddr = {1'b0, dispRow, 5'b0} + {3'b0, dispRow, 3'b0} + {5'b0, dispCol};

    // Gating with reset_n keeps the RAM port quiet during reset.
    dispFetch = reset_n && dispSlot && rowOk;
    cpuLegal  = (cpu_addr < ADDR_LIMIT);
    cpuIssue  = reset_n && (state == IDLE) && cpu_req && !cpu_ack && !dispSlot;
    cpuDrive  = cpuIssue && cpuLegal;

    mem_addr  = memAddrQ;
    mem_we    = 1'b0;
    mem_wdata = 8'h00;
    if (dispFetch) begin
      mem_addr = dispAddr;
    end else if (cpuDrive) begin
      mem_addr = cpu_addr;
      if (cpu_we) begin
        mem_we    = 1'b1;
        mem_wdata = cpu_wdata;
      end
    end
  end

  // Display pipeline: address in cycle I, RAM data lands in tile_idx at the end of I+1.
  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      memAddrQ   <= 11'd0;
      dispPend   <= 1'b0;
      dispMiss   <= 1'b0;
      tile_idx   <= 8'h00;
      tile_valid <= 1'b0;
    end else begin
      memAddrQ <= mem_addr;
      dispPend <= dispFetch;
      dispMiss <= dispSlot && !rowOk;
      if (hCount == H_ACTIVE_END) begin
        tile_valid <= 1'b0;
      end else if (dispPend) begin
        tile_idx   <= mem_rdata;
        tile_valid <= 1'b1;
      end else if (dispMiss) begin
        tile_valid <= 1'b0;
      end
    end
  end

  // CPU access controller: issue, one cycle in flight, then a one-cycle ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cpu_ack   <= 1'b0;
      cpu_rdata <= 8'h00;
      cpuReadQ  <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (cpuIssue) begin
            state    <= CPU_WAIT;
            cpuReadQ <= !cpu_we && cpuLegal;
          end
        end
        CPU_WAIT: begin
          // Out-of-range reads and all writes return zero.
          cpu_rdata <= cpuReadQ ? mem_rdata : 8'h00;
          cpu_ack   <= 1'b1;
          state     <= CPU_ACK;
        end
        CPU_ACK: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_tile_arbiter.sv
// Self-checking bench for vga_tile_arbiter: a synchronous tile RAM model, a beam
// driver, and a scoreboard of expected CPU read data popped on every cpu_ack.
module tb_vga_tile_arbiter;

  localparam int HLAST = 784;
  localparam int VLAST = 524;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  hCount;
  logic [9:0]  vCount;
  logic        cpu_req;
  logic        cpu_we;
  logic [10:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [10:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  tile_idx;
  logic        tile_valid;

  always #5 clk = ~clk;

  vga_tile_arbiter #(.COLS(40), .ROWS(30), .HLAST(HLAST), .VLAST(VLAST)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .hCount     (hCount),
    .vCount     (vCount),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .tile_idx   (tile_idx),
    .tile_valid (tile_valid)
  );

  // Tile RAM model: port sampled mid-cycle, read data valid one cycle after the address.
  logic [7:0]  ram    [0:2047];
  logic [7:0]  shadow [0:2047];
  logic [10:0] capAddr  = 11'd0;
  logic        capWe    = 1'b0;
  logic [7:0]  capWdata = 8'h00;

  always @(negedge clk) begin
    capAddr  <= mem_addr;
    capWe    <= mem_we;
    capWdata <= mem_wdata;
  end

  always @(posedge clk) begin
    mem_rdata <= ram[capAddr];
    if (capWe) ram[capAddr] <= capWdata;
  end

  int assertCount = 0;
  int failCount   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic       isWrite;
    logic [7:0] rdata;
  } expT;

  expT expQ[$];
  bit  armed     = 1'b0;
  int  sinceJump = 0;

  function automatic bit isSlot(input logic [9:0] h);
    return ((h[3:0] == 4'd14) && (h[9:4] <= 6'd38)) || (h == 10'(HLAST - 1));
  endfunction

  // Monitor: display fetches, tile outputs and the CPU scoreboard, every cycle.
  int  mLine;
  int  mCol;
  expT mExp;
  logic prevAck = 1'b0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (isSlot(hCount)) begin
        if (hCount == 10'(HLAST - 1)) begin
          mLine = (vCount == 10'(VLAST)) ? 0 : int'(vCount) + 1;
          mCol  = 0;
        end else begin
          mLine = int'(vCount);
          mCol  = int'(hCount[9:4]) + 1;
        end
        if (mLine < 480) begin
          check("disp_addr", mem_addr, (mLine / 16) * 40 + mCol);
          check("disp_we", mem_we, 0);
        end
      end
      if (armed) begin
        if (hCount < 640 && vCount < 480) begin
          check("tile_valid", tile_valid, 1);
          check("tile_idx", tile_idx, shadow[(int'(vCount) / 16) * 40 + int'(hCount) / 16]);
        end else begin
          check("tile_blank", tile_valid, 0);
        end
      end
      if (cpu_ack) begin
        check("ack_pulse", prevAck, 0);
        if (expQ.size() == 0) begin
          check("ack_expected", 0, 1);
        end else begin
          mExp = expQ.pop_front();
          if (!mExp.isWrite) check("cpu_rdata", cpu_rdata, mExp.rdata);
        end
      end
    end
    prevAck = cpu_ack;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (hCount == 10'(HLAST)) begin
      hCount = 10'd0;
      vCount = (vCount == 10'(VLAST)) ? 10'd0 : vCount + 10'd1;
    end else begin
      hCount = hCount + 10'd1;
    end
    sinceJump++;
    if (hCount == 10'd0 && sinceJump >= 2 && reset_n) armed = 1'b1;
  endtask

  task automatic setTiming(input logic [9:0] h, input logic [9:0] v);
    @(posedge clk);
    #1;
    hCount    = h;
    vCount    = v;
    armed     = 1'b0;
    sinceJump = 0;
  endtask

  task automatic tickUntil(input logic [9:0] h, input logic [9:0] v);
    int n = 0;
    while (!(hCount == h && vCount == v) && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) check("timing_reach", 0, 1);
  endtask

  task automatic checkZero(input string tag);
    check(tag, {tile_idx, tile_valid, cpu_ack, cpu_rdata}, 0);
    check({tag, "_mem"}, {mem_addr, mem_we, mem_wdata}, 0);
  endtask

  // Drives one request in the current cycle and follows it to its ack.
  task automatic cpuAccess(input logic we, input logic [10:0] addr, input logic [7:0] data,
                           input bit hold);
    int  lat;
    bit  legal;
    bit  seen;
    expT e;
    lat       = isSlot(hCount) ? 3 : 2;
    legal     = (addr < 11'd1200);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = data;
    e.isWrite = we;
    e.rdata   = (!we && legal) ? shadow[addr] : 8'h00;
    expQ.push_back(e);
    if (we && legal) shadow[addr] = data;
    seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      @(negedge clk);
      if (k == lat - 2) begin
        check("issue_we", mem_we, we && legal);
        if (legal) check("issue_addr", mem_addr, addr);
        if (we && legal) check("issue_wdata", mem_wdata, data);
      end
      if (!legal) check("illegal_we", mem_we, 0);
      if (cpu_ack) begin
        seen = 1'b1;
        check("ack_latency", k, lat);
      end
      tick();
    end
    if (!seen) check("ack_timeout", 0, 1);
    if (!hold) cpu_req = 1'b0;
  endtask

  // Back-to-back table: {we, addr, wdata}.
  logic [19:0] burst [12] = '{
    {1'b0, 11'd0,    8'h00}, {1'b1, 11'd1199, 8'h5A}, {1'b0, 11'd1199, 8'h00},
    {1'b0, 11'd40,   8'h00}, {1'b0, 11'd1200, 8'h00}, {1'b0, 11'd7,    8'h00},
    {1'b0, 11'd5,    8'h00}, {1'b1, 11'd300,  8'h3C}, {1'b0, 11'd300,  8'h00},
    {1'b0, 11'd1000, 8'h00}, {1'b0, 11'd1,    8'h00}, {1'b0, 11'd2,    8'h00}
  };

  initial begin
    logic [19:0] entry;
    reset_n   = 1'b0;
    hCount    = 10'd14;
    vCount    = 10'd0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 11'd0;
    cpu_wdata = 8'h00;
    for (int i = 0; i < 2048; i++) begin
      ram[i]    = 8'(i);
      shadow[i] = 8'(i);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkZero("reset_state");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Row 0 sweep: glyph index follows the column, changing on 16-pixel boundaries.
    setTiming(10'd770, 10'(VLAST));
    tickUntil(10'd0, 10'd0);
    while (hCount < 10'd640) begin
      @(negedge clk);
      if (hCount[3:0] == 4'd0) check("sweep_idx", tile_idx, hCount[9:4]);
      tick();
    end

    // Next-line prefetch, and no prefetch past the last active row.
    setTiming(10'd770, 10'd16);
    tickUntil(10'(HLAST - 1), 10'd16);
    @(negedge clk);
    check("nextline_addr", mem_addr, 40);
    tickUntil(10'd0, 10'd17);
    @(negedge clk);
    check("nextline_idx", tile_idx, 40);
    check("nextline_valid", tile_valid, 1);
    tickUntil(10'd100, 10'd17);
    setTiming(10'd770, 10'd479);
    tickUntil(10'(HLAST - 1), 10'd479);
    @(negedge clk);
    check("lastrow_we", mem_we, 0);
    tickUntil(10'd0, 10'd480);
    @(negedge clk);
    check("lastrow_valid", tile_valid, 0);
    tickUntil(10'd40, 10'd480);

    // CPU traffic on an active line.
    setTiming(10'd770, 10'd99);
    tickUntil(10'd0, 10'd100);
    tickUntil(10'd14, 10'd100);
    cpuAccess(1'b1, 11'd5, 8'hA5, 1'b0);
    repeat (2) tick();
    cpuAccess(1'b0, 11'd5, 8'h00, 1'b0);
    cpuAccess(1'b0, 11'd1300, 8'h00, 1'b0);
    cpuAccess(1'b1, 11'd1200, 8'h77, 1'b0);
    tick();
    for (int i = 0; i < 12; i++) begin
      entry = burst[i];
      cpuAccess(entry[19], entry[18:8], entry[7:0], i != 11);
    end

    // Reset during cycle I+1 of a write abandons it.
    while (hCount[3:0] != 4'd2) tick();
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 11'd7;
    cpu_wdata = 8'h3C;
    shadow[7] = 8'h3C;
    @(negedge clk);
    check("rst_issue_we", mem_we, 1);
    tick();
    reset_n = 1'b0;
    cpu_req = 1'b0;
    armed   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checkZero("rst_mid");
      tick();
    end
    reset_n   = 1'b1;
    sinceJump = 0;
    expQ.delete();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst_ack", cpu_ack, 0);
      check("post_rst_we", mem_we, 0);
      tick();
    end
    cpuAccess(1'b1, 11'd7, 8'h3C, 1'b0);
    cpuAccess(1'b0, 11'd7, 8'h00, 1'b0);
    repeat (4) tick();

    @(negedge clk);
    check("queue_drained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/vga_tile_arbiter.md
VGA_TILE_ARBITER -- requirements
Module: vga_tile_arbiter

Interface
REQ-001 Parameters (name, default, meaning): COLS, 40, tile columns; ROWS, 30, tile rows; HLAST, 784, final hCount value of a scanline; VLAST, 524, final vCount value of a frame.
REQ-002 Port list, one entry per line (name, direction, width, meaning): clk, in, 1, pixel clock, all logic on rising edge.
REQ-003 reset_n, in, 1, asynchronous active-low reset.
REQ-004 hCount, in, 10, horizontal count from the VGA timing generator.
REQ-005 vCount, in, 10, vertical count from the VGA timing generator.
REQ-006 cpu_req, in, 1, CPU access request, held high until cpu_ack.
REQ-007 cpu_we, in, 1, 1=write, 0=read; stable while cpu_req is high.
REQ-008 cpu_addr, in, 11, tile address (row*40+col); stable while cpu_req is high.
REQ-009 cpu_wdata, in, 8, write data.
REQ-010 cpu_ack, out, 1, one-cycle completion pulse.
REQ-011 cpu_rdata, out, 8, read data, valid while cpu_ack is high.
REQ-012 mem_addr, out, 11, single-port tile RAM address.
REQ-013 mem_we, out, 1, tile RAM write strobe.
REQ-014 mem_wdata, out, 8, tile RAM write data.
REQ-015 mem_rdata, in, 8, tile RAM read data, valid one cycle after the address is issued.
REQ-016 tile_idx, out, 8, glyph index for the 16x16 block currently being scanned.
REQ-017 tile_valid, out, 1, tile_idx belongs to the active 640x480 area.

Function
REQ-018 The tile RAM port SHALL issue at most one access per cycle; the cycle in which mem_addr is driven is the issue cycle I.
REQ-019 A display slot SHALL occur when hCount[3:0]==14 with hCount[9:4]<=38; it fetches column hCount[9:4]+1 of row vCount[8:4], provided vCount<480.
REQ-020 A display slot SHALL also occur at hCount==HLAST-1; it fetches column 0 of row nl[8:4], where nl = (vCount==VLAST) ? 0 : vCount+1, provided nl<480.
REQ-021 Display slots SHALL always win the issue cycle and SHALL never be delayed; mem_we is 0 in a display slot.
REQ-022 Display read data SHALL be registered into tile_idx at the end of cycle I+1, so that tile_idx changes exactly when hCount[3:0] becomes 0.
REQ-023 tile_valid SHALL be updated at the same edge as tile_idx: set to 1 for an issued display slot, and cleared to 0 at the edge where hCount goes to 640 or the slot's row is >=480.
REQ-024 Addresses SHALL be computed as row*32+row*8+col without a multiplier; the maximum legal address is 1199.
REQ-025 A CPU access SHALL be issued in the first cycle meeting all of: cpu_req=1, no display slot, no CPU access in flight, cpu_ack=0.
REQ-026 CPU write: mem_we=1 and mem_wdata=cpu_wdata in cycle I.
REQ-027 CPU read: mem_rdata SHALL be captured into cpu_rdata at the end of cycle I+1.
REQ-028 cpu_ack SHALL be high for exactly cycle I+2, for both reads and writes.
REQ-029 If cpu_req conflicts with a display slot, the CPU access SHALL slip exactly one cycle.
REQ-030 Worst-case latency SHALL be 3 cycles from cpu_req rising to cpu_ack; minimum spacing between CPU issues SHALL be 3 cycles.
REQ-031 A cpu_addr>=1200 SHALL NOT drive the RAM: mem_we=0, and the access is still acknowledged with the same timing, with cpu_rdata=0.
REQ-032 The controller SHALL be an FSM with states IDLE, CPU_WAIT (in flight) and CPU_ACK; IDLE->CPU_WAIT on CPU issue, CPU_WAIT->CPU_ACK after 1 cycle, CPU_ACK->IDLE unconditionally.
REQ-033 Display slots SHALL be serviced in any FSM state.
REQ-034 When idle, mem_we=0, mem_wdata=0, and mem_addr holds its last value.

Reset
REQ-035 While reset_n=0 the block SHALL hold: tile_idx=0, tile_valid=0, cpu_ack=0, cpu_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0, FSM=IDLE.
REQ-036 Reset asserted mid-access SHALL abandon the access, with no ack and no write after reset_n rises.
REQ-037 The CPU SHALL re-request after a reset that abandons its access.

Verification
REQ-038 Memory preloaded with addr[7:0], vCount=0, hCount sweep 0..639 -> tile_idx = 0,1,...,39, each changing when hCount[3:0]==0; tile_valid=1.
REQ-039 vCount=16, hCount=783 -> mem_addr=40; at hCount=0 of line 17, tile_idx=40. vCount=479, hCount=783 -> no fetch, tile_valid=0.
REQ-040 cpu_req write addr=5 data=0xA5 raised at hCount=14 -> issue at hCount 15; cpu_ack 2 cycles later; a later read of addr 5 returns 0xA5.
REQ-041 cpu_req read addr=1300 -> mem_we never 1; cpu_ack with cpu_rdata=0.
REQ-042 cpu_req held high continuously -> cpu_ack pulses every 3 cycles, or 4 when a slip occurs; display tile_idx remains correct throughout.
REQ-043 reset_n dropped in cycle I+1 of a write -> no cpu_ack, and all outputs are 0 until release.
